// File: rtl/jtdsp16_sio.sv
// jtdsp16_sio: DSP16 serial I/O unit (sdx output shifter, input deserializer).
// Build option: define JTDSP16_SIO_LOOPBACK_EN to feed the input path from sdo/ock/old.
module jtdsp16_sio #(
    parameter int OCK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        sdx_wr,
    input  logic [15:0] sdx_din,
    input  logic        sdx_rd,
    output logic [15:0] sdx_dout,
    input  logic        olen16,
    input  logic        ilen16,
    input  logic        msb_first,
    output logic        sdo,
    output logic        ock,
    output logic        old,
    output logic        ose,
    output logic        doen,
    input  logic        di,
    input  logic        ick,
    input  logic        ild,
    output logic        ibf,
    output logic        siowr_empty,
    output logic        siord_full
);

    localparam int HALF = OCK_DIV / 2;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    // ---------------- bit clock ----------------
    logic [CW-1:0] div_q;
    logic          ock_q;
    logic          half_end;
    logic          fall;

    assign half_end = (div_q == CW'(HALF - 1));
    assign fall     = cen & half_end & ock_q;

    // Free-running divider: ock toggles every HALF cen ticks
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            ock_q <= 1'b0;
        end else if (cen) begin
            if (half_end) begin
                div_q <= '0;
                ock_q <= ~ock_q;
            end else begin
                div_q <= div_q + CW'(1);
            end
        end
    end

    // ---------------- output path ----------------
    logic [0:0]  state_q, state_d;
    logic [15:0] obuf_q, obuf_d;
    logic        obuf_full_q, obuf_full_d;
    logic [15:0] osr_q, osr_d;
    logic [3:0]  obit_q, obit_d;
    logic        olen_q, olen_d;
    logic        omsb_q, omsb_d;
    logic        sdo_q, sdo_d;
    logic        old_q, old_d;
    logic        doen_q, doen_d;
    logic        ose_q, ose_d;
    logic        load;
    logic        first_bit;
    logic        next_bit;

    // First bit of the buffered word, using the word length/order at load time
    always_comb begin
        if (msb_first) first_bit = olen16 ? obuf_q[15] : obuf_q[7];
        else           first_bit = obuf_q[0];
    end

    // Bit that follows the current one in the shift register
    always_comb begin
        if (omsb_q) next_bit = olen_q ? osr_q[14] : osr_q[6];
        else        next_bit = osr_q[1];
    end

    // Output FSM: loads on ock fall, shifts one bit per fall, reloads back-to-back
    always_comb begin
        state_d     = state_q;
        obuf_d      = obuf_q;
        obuf_full_d = obuf_full_q;
        osr_d       = osr_q;
        obit_d      = obit_q;
        olen_d      = olen_q;
        omsb_d      = omsb_q;
        sdo_d       = sdo_q;
        old_d       = old_q;
        doen_d      = doen_q;
        ose_d       = ose_q;
        load        = 1'b0;
        if (fall) begin
            unique case (state_q)
                S_IDLE: begin
                    load = obuf_full_q;
                end
                S_SHIFT: begin
                    old_d = 1'b0;
                    if (obit_q != 4'd0) begin
                        osr_d  = omsb_q ? (osr_q << 1) : (osr_q >> 1);
                        sdo_d  = next_bit;
                        obit_d = obit_q - 4'd1;
                    end else if (obuf_full_q) begin
                        load = 1'b1;
                    end else begin
                        sdo_d   = 1'b0;
                        doen_d  = 1'b0;
                        ose_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        if (load) begin
            osr_d       = obuf_q;
            olen_d      = olen16;
            omsb_d      = msb_first;
            obit_d      = olen16 ? 4'd15 : 4'd7;
            sdo_d       = first_bit;
            old_d       = 1'b1;
            doen_d      = 1'b1;
            ose_d       = 1'b0;
            obuf_full_d = 1'b0;
            state_d     = S_SHIFT;
        end
        // A CPU write in the same cycle as a transfer keeps the buffer full
        if (cen && sdx_wr) begin
            obuf_d      = sdx_din;
            obuf_full_d = 1'b1;
        end
    end

    // Output path registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            obuf_q      <= '0;
            obuf_full_q <= 1'b0;
            osr_q       <= '0;
            obit_q      <= '0;
            olen_q      <= 1'b1;
            omsb_q      <= 1'b1;
            sdo_q       <= 1'b0;
            old_q       <= 1'b0;
            doen_q      <= 1'b0;
            ose_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            obuf_q      <= obuf_d;
            obuf_full_q <= obuf_full_d;
            osr_q       <= osr_d;
            obit_q      <= obit_d;
            olen_q      <= olen_d;
            omsb_q      <= omsb_d;
            sdo_q       <= sdo_d;
            old_q       <= old_d;
            doen_q      <= doen_d;
            ose_q       <= ose_d;
        end
    end

    // ---------------- input path ----------------
    logic src_di, src_ick, src_ild;

`ifdef JTDSP16_SIO_LOOPBACK_EN
    logic unused_pins;
    assign unused_pins = ^{di, ick, ild};
    assign src_di  = sdo_q;
    assign src_ick = ock_q;
    assign src_ild = old_q;
`else
    assign src_di  = di;
    assign src_ick = ick;
    assign src_ild = ild;
`endif

    logic [1:0]  di_sq, ick_sq, ild_sq;
    logic        ick_prev_q;
    logic        ick_rise;
    logic [15:0] isr_q, isr_d;
    logic [4:0]  ibit_q, ibit_d;
    logic        iact_q, iact_d;
    logic        ilen_q, ilen_d;
    logic        imsb_q, imsb_d;
    logic [15:0] ibuf_q, ibuf_d;
    logic        ibf_q, ibf_d;
    logic        fr_len16, fr_msb, capture, done;

    assign ick_rise = ick_sq[1] & ~ick_prev_q;

    // Two-flop synchronizers for the asynchronous serial inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            di_sq      <= '0;
            ick_sq     <= '0;
            ild_sq     <= '0;
            ick_prev_q <= 1'b0;
        end else begin
            di_sq      <= {di_sq[0], src_di};
            ick_sq     <= {ick_sq[0], src_ick};
            ild_sq     <= {ild_sq[0], src_ild};
            ick_prev_q <= ick_sq[1];
        end
    end

    // Deserializer: ild starts a frame, each ick rise captures one bit
    always_comb begin
        isr_d    = isr_q;
        ibit_d   = ibit_q;
        iact_d   = iact_q;
        ilen_d   = ilen_q;
        imsb_d   = imsb_q;
        ibuf_d   = ibuf_q;
        ibf_d    = ibf_q;
        capture  = 1'b0;
        fr_len16 = ild_sq[1] ? ilen16 : ilen_q;
        fr_msb   = ild_sq[1] ? msb_first : imsb_q;
        if (ick_rise) begin
            if (ild_sq[1]) begin
                ilen_d  = ilen16;
                imsb_d  = msb_first;
                isr_d   = msb_first ? {15'd0, di_sq[1]} : {di_sq[1], 15'd0};
                ibit_d  = 5'd1;
                iact_d  = 1'b1;
                capture = 1'b1;
            end else if (iact_q) begin
                isr_d   = imsb_q ? {isr_q[14:0], di_sq[1]}
                                 : {di_sq[1], isr_q[15:1]};
                ibit_d  = ibit_q + 5'd1;
                capture = 1'b1;
            end
        end
        done = capture && (ibit_d == (fr_len16 ? 5'd16 : 5'd8));
        if (done) begin
            if (fr_msb || fr_len16) ibuf_d = isr_d;
            else                    ibuf_d = {8'h00, isr_d[15:8]};
            ibf_d  = 1'b1;
            iact_d = 1'b0;
            ibit_d = 5'd0;
        end else if (cen && sdx_rd) begin
            ibf_d = 1'b0;
        end
    end

    // Input path registers
    always_ff @(posedge clk) begin
        if (rst) begin
            isr_q  <= '0;
            ibit_q <= '0;
            iact_q <= 1'b0;
            ilen_q <= 1'b1;
            imsb_q <= 1'b1;
            ibuf_q <= '0;
            ibf_q  <= 1'b0;
        end else begin
            isr_q  <= isr_d;
            ibit_q <= ibit_d;
            iact_q <= iact_d;
            ilen_q <= ilen_d;
            imsb_q <= imsb_d;
            ibuf_q <= ibuf_d;
            ibf_q  <= ibf_d;
        end
    end

    assign sdo         = sdo_q;
    assign ock         = ock_q;
    assign old         = old_q;
    assign ose         = ose_q;
    assign doen        = doen_q;
    assign sdx_dout    = ibuf_q;
    assign ibf         = ibf_q;
    assign siord_full  = ibf_q;
    assign siowr_empty = ~obuf_full_q;

endmodule
